// File: rtl/fsm_oe16s_pkg.sv
// Shared types and helpers for the 16-state one-hot FSM transition-table loader.
//   entry_t    : one transition-table entry {en, sel, target}
//   ctl_state_t: loader control FSM states
//   def_entry  : default (self-loop, disabled) entry for a given state
package fsm_oe16s_pkg;

   localparam int NSTATES = 16;

   // Storage width of the condition select. It is wider than any supported
   // condition index (NCOND up to 128). Writes zero-extend, so only the low
   // $clog2(NCOND) bits are ever non-zero.
   localparam int SEL_W = 8;

   typedef struct packed {
      logic             en;
      logic [SEL_W-1:0] sel;
      logic [3:0]       target;
   } entry_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      COMMIT = 2'd1,
      CLEAR  = 2'd2
   } ctl_state_t;

   // Default entry: disabled, condition 0, target = own state (self-loop).
   function automatic entry_t def_entry(input logic [3:0] y);
      entry_t e;
      e.en     = 1'b0;
      e.sel    = '0;
      e.target = y;
      return e;
   endfunction

endpackage

// File: rtl/fsm_oe16s_table_loader_if.sv
// Software-side port of the table loader: entry write handshake plus the
// commit/clear requests and status.
//   master: drives wr_valid/wr_state/wr_target/wr_sel/wr_en/commit_req/clear_req
//   slave : drives wr_ready/busy/commit_done
interface fsm_oe16s_table_loader_if #(
   parameter int NCOND = 4
);
   localparam int CSW = $clog2(NCOND);

   logic           wr_valid;
   logic           wr_ready;
   logic [3:0]     wr_state;
   logic [3:0]     wr_target;
   logic [CSW-1:0] wr_sel;
   logic           wr_en;
   logic           commit_req;
   logic           clear_req;
   logic           busy;
   logic           commit_done;

   modport master (
      output wr_valid, wr_state, wr_target, wr_sel, wr_en, commit_req, clear_req,
      input  wr_ready, busy, commit_done
   );

   modport slave (
      input  wr_valid, wr_state, wr_target, wr_sel, wr_en, commit_req, clear_req,
      output wr_ready, busy, commit_done
   );

endinterface

// File: rtl/fsm_oe16s_cond_mux.sv
// Combinational next-state generator for one state of the one-hot FSM.
//   ent       in  active table entry for this state
//   cond      in  condition inputs
//   self_code in  this state's own code (used for the self-loop)
//   t_code    out next-state code: target when enabled and condition true, else self
module fsm_oe16s_cond_mux
   import fsm_oe16s_pkg::*;
#(
   parameter int NCOND = 4
) (
   input  entry_t           ent,
   input  logic [NCOND-1:0] cond,
   input  logic [3:0]       self_code,
   output logic [3:0]       t_code
);
   localparam int CSW = $clog2(NCOND);
   localparam logic [SEL_W-1:0] NCOND_W = SEL_W'(NCOND);

   logic sel_ok;
   logic cond_hit;

   // The range check keeps an out-of-range select (never written by the
   // loader) from aliasing onto a real condition.
   assign sel_ok   = (ent.sel < NCOND_W);
   assign cond_hit = sel_ok && cond[ent.sel[CSW-1:0]];
   assign t_code   = (ent.en && cond_hit) ? ent.target : self_code;

endmodule

// File: rtl/fsm_oe16s_table_loader.sv
// Programmable transition-table source for a 16-state one-hot FSM.
// Software fills a shadow table entry by entry; a commit copies the whole
// shadow into the active table in one cycle; a clear sweeps the shadow back
// to defaults over 16 cycles without touching the active table.
//   clk, rst_n   clock and asynchronous active-low reset
//   bus          write handshake, commit/clear requests, busy/commit_done
//   cond         condition inputs gating each active entry
//   t0x..tfx     next-state code for current states 0..15
module fsm_oe16s_table_loader
   import fsm_oe16s_pkg::*;
#(
   parameter int NCOND = 4   // power of two, 2..128
) (
   input  logic                            clk,
   input  logic                            rst_n,
   fsm_oe16s_table_loader_if.slave         bus,
   input  logic [NCOND-1:0]                cond,
   output logic [3:0]                      t0x,
   output logic [3:0]                      t1x,
   output logic [3:0]                      t2x,
   output logic [3:0]                      t3x,
   output logic [3:0]                      t4x,
   output logic [3:0]                      t5x,
   output logic [3:0]                      t6x,
   output logic [3:0]                      t7x,
   output logic [3:0]                      t8x,
   output logic [3:0]                      t9x,
   output logic [3:0]                      tax,
   output logic [3:0]                      tbx,
   output logic [3:0]                      tcx,
   output logic [3:0]                      tdx,
   output logic [3:0]                      tex,
   output logic [3:0]                      tfx
);

   ctl_state_t state_reg, state_next;
   logic [3:0] clr_cnt_reg, clr_cnt_next;

   entry_t shadow_reg [NSTATES];
   entry_t active_reg [NSTATES];
   entry_t wr_entry;

   logic do_write;
   logic do_commit;
   logic do_clear;
   logic wr_ready_int;
   logic busy_int;
   logic commit_done_int;

   logic [3:0] t_arr [NSTATES];

   // ---------------- control FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         clr_cnt_reg <= 4'd0;
      end else begin
         state_reg   <= state_next;
         clr_cnt_reg <= clr_cnt_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      clr_cnt_next    = clr_cnt_reg;
      wr_ready_int    = 1'b0;
      busy_int        = 1'b0;
      commit_done_int = 1'b0;
      do_write        = 1'b0;
      do_commit       = 1'b0;
      do_clear        = 1'b0;
      case (state_reg)
         IDLE: begin
            // rst_n gating keeps wr_ready low while reset is held.
            wr_ready_int = rst_n;
            do_write     = bus.wr_valid && rst_n;
            if (bus.clear_req) begin
               state_next   = CLEAR;
               clr_cnt_next = 4'd0;
            end else if (bus.commit_req) begin
               state_next = COMMIT;
            end
         end
         COMMIT: begin
            busy_int        = 1'b1;
            commit_done_int = 1'b1;
            do_commit       = 1'b1;
            state_next      = IDLE;
         end
         CLEAR: begin
            busy_int     = 1'b1;
            do_clear     = 1'b1;
            clr_cnt_next = clr_cnt_reg + 4'd1;
            if (clr_cnt_reg == 4'd15) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign bus.wr_ready    = wr_ready_int;
   assign bus.busy        = busy_int;
   assign bus.commit_done = commit_done_int;

   always_comb begin
      wr_entry        = '0;
      wr_entry.en     = bus.wr_en;
      wr_entry.sel    = SEL_W'(bus.wr_sel);
      wr_entry.target = bus.wr_target;
   end

   // ---------------- tables and output muxes ----------------
   generate
      for (genvar gi = 0; gi < NSTATES; gi++) begin : g_entry
         // Writes only happen in IDLE and the sweep only in CLEAR, so the two
         // never compete for the same entry in one cycle.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               shadow_reg[gi] <= def_entry(4'(gi));
            end else if (do_clear && (clr_cnt_reg == 4'(gi))) begin
               shadow_reg[gi] <= def_entry(4'(gi));
            end else if (do_write && (bus.wr_state == 4'(gi))) begin
               shadow_reg[gi] <= wr_entry;
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               active_reg[gi] <= def_entry(4'(gi));
            end else if (do_commit) begin
               active_reg[gi] <= shadow_reg[gi];
            end
         end

         fsm_oe16s_cond_mux #(
            .NCOND (NCOND)
         ) u_mux (
            .ent       (active_reg[gi]),
            .cond      (cond),
            .self_code (4'(gi)),
            .t_code    (t_arr[gi])
         );
      end
   endgenerate

   assign t0x = t_arr[0];
   assign t1x = t_arr[1];
   assign t2x = t_arr[2];
   assign t3x = t_arr[3];
   assign t4x = t_arr[4];
   assign t5x = t_arr[5];
   assign t6x = t_arr[6];
   assign t7x = t_arr[7];
   assign t8x = t_arr[8];
   assign t9x = t_arr[9];
   assign tax = t_arr[10];
   assign tbx = t_arr[11];
   assign tcx = t_arr[12];
   assign tdx = t_arr[13];
   assign tex = t_arr[14];
   assign tfx = t_arr[15];

endmodule
